// File: rtl/session_controller.sv
// rtl/session_controller.sv - login session supervisor: idle/guest timeouts and acknowledged logout
module session_controller #(
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int IDLE_TIMEOUT_S = 30,
    parameter int GUEST_LIMIT_S  = 60,
    parameter int WARN_S         = 5,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LoggedIn,
    input  logic       LoggedOut,
    input  logic       isGuest,
    input  logic [4:0] PlayerAddress,
    input  logic       Activity,
    input  logic       LogoutReq,
    output logic       LogoutCommand,
    output logic       SessionActive,
    output logic       SessionGuest,
    output logic [4:0] SessionAddress,
    output logic [7:0] IdleLeft,
    output logic       IdleWarn,
    output logic [1:0] LogoutCause
);
    localparam int PRESCALE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] IDLE_RELOAD = 8'(IDLE_TIMEOUT_S);
    localparam logic [7:0] GUEST_RELOAD = 8'(GUEST_LIMIT_S);
    localparam logic [7:0] WARN_LEVEL = 8'(WARN_S);
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_USER  = 2'b01;
    localparam logic [1:0] CAUSE_IDLE  = 2'b10;
    localparam logic [1:0] CAUSE_GUEST = 2'b11;

    typedef enum logic [1:0] {IDLE, ACTIVE, LOGOUT, WAIT_ACK} sessionState;

    sessionState state;
    sessionState nextState;
    logic [PRESCALE_W-1:0] prescaler;
    logic [7:0] guestLeft;
    logic [7:0] ackCount;
    logic [1:0] causeNext;
    logic secTick;
    logic idleExpire;
    logic guestExpire;

    assign secTick     = (state == ACTIVE) && (prescaler == PRESCALE_LAST);
    // Activity on the expiring tick reloads the idle timer, so it also cancels the idle logout.
    assign idleExpire  = secTick && !Activity && (IdleLeft == 8'd1);
    assign guestExpire = secTick && SessionGuest && (guestLeft == 8'd1);

    assign LogoutCommand = (state == LOGOUT);
    assign SessionActive = (state == ACTIVE);
    assign IdleWarn      = (state == ACTIVE) && (IdleLeft <= WARN_LEVEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        causeNext = LogoutCause;
        case (state)
            IDLE: begin
                if (LoggedIn) begin
                    nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (LoggedOut) begin
                    nextState = IDLE;
                end else if (LogoutReq) begin
                    nextState = LOGOUT;
                    causeNext = CAUSE_USER;
                end else if (idleExpire) begin
                    nextState = LOGOUT;
                    causeNext = CAUSE_IDLE;
                end else if (guestExpire) begin
                    nextState = LOGOUT;
                    causeNext = CAUSE_GUEST;
                end
            end
            LOGOUT: begin
                nextState = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (LoggedOut) begin
                    nextState = IDLE;
                end else if (ackCount == ACK_LIMIT) begin
                    nextState = LOGOUT;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler      <= '0;
            guestLeft      <= '0;
            ackCount       <= '0;
            IdleLeft       <= '0;
            SessionGuest   <= 1'b0;
            SessionAddress <= '0;
            LogoutCause    <= CAUSE_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (LoggedIn) begin
                        SessionAddress <= PlayerAddress;
                        SessionGuest   <= isGuest;
                        IdleLeft       <= IDLE_RELOAD;
                        guestLeft      <= GUEST_RELOAD;
                        prescaler      <= '0;
                        LogoutCause    <= CAUSE_NONE;
                    end
                end
                ACTIVE: begin
                    prescaler <= secTick ? '0 : prescaler + 1'b1;
                    if (Activity) begin
                        IdleLeft <= IDLE_RELOAD;
                    end else if (secTick && (IdleLeft != 8'd0)) begin
                        IdleLeft <= IdleLeft - 8'd1;
                    end
                    if (secTick && SessionGuest && (guestLeft != 8'd0)) begin
                        guestLeft <= guestLeft - 8'd1;
                    end
                    LogoutCause <= causeNext;
                end
                LOGOUT: begin
                    ackCount <= '0;
                end
                WAIT_ACK: begin
                    if (!LoggedOut && (ackCount != ACK_LIMIT)) begin
                        ackCount <= ackCount + 8'd1;
                    end
                end
                default: begin
                    ackCount <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_session_controller.sv
// tb/tb_session_controller.sv - randomized scoreboard bench for session_controller
module tb_session_controller;
    localparam int TPS = 4;
    localparam int IDLE_S = 3;
    localparam int GUEST_S = 5;
    localparam int WARN = 1;
    localparam int ACK = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic LoggedIn = 1'b0;
    logic LoggedOut = 1'b0;
    logic isGuest = 1'b0;
    logic [4:0] PlayerAddress = '0;
    logic Activity = 1'b0;
    logic LogoutReq = 1'b0;
    logic LogoutCommand;
    logic SessionActive;
    logic SessionGuest;
    logic [4:0] SessionAddress;
    logic [7:0] IdleLeft;
    logic IdleWarn;
    logic [1:0] LogoutCause;

    session_controller #(
        .TICKS_PER_SEC(TPS),
        .IDLE_TIMEOUT_S(IDLE_S),
        .GUEST_LIMIT_S(GUEST_S),
        .WARN_S(WARN),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .LoggedIn(LoggedIn),
        .LoggedOut(LoggedOut),
        .isGuest(isGuest),
        .PlayerAddress(PlayerAddress),
        .Activity(Activity),
        .LogoutReq(LogoutReq),
        .LogoutCommand(LogoutCommand),
        .SessionActive(SessionActive),
        .SessionGuest(SessionGuest),
        .SessionAddress(SessionAddress),
        .IdleLeft(IdleLeft),
        .IdleWarn(IdleWarn),
        .LogoutCause(LogoutCause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic active;
        logic cmd;
        logic checkIdle;
        logic warn;
        logic guest;
        logic [7:0] idle;
        logic [4:0] addr;
        logic [1:0] cause;
    } snapT;

    typedef struct {
        int cycle;
        logic [1:0] cause;
    } cmdT;

    snapT snapQ[$];
    cmdT cmdQ[$];
    int obsCmd[$];

    // Reference: session age in cycles, ticks since last activity, guest ticks consumed,
    // and the phase within the (ACK+2)-cycle logout retry period.
    int mMode = 0;
    int mAge = 0;
    int mTsa = 0;
    int mTt = 0;
    int mPhase = 0;
    logic mGuest = 1'b0;
    logic [4:0] mAddr = '0;
    logic [1:0] mCause = '0;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic pushCmd(input logic [1:0] cause);
        cmdT c;
        mMode = 2;
        mPhase = 0;
        mCause = cause;
        c.cycle = cyc + 1;
        c.cause = cause;
        cmdQ.push_back(c);
    endtask

    task automatic modelStep(input logic li, input logic lo, input logic g, input logic [4:0] a,
                             input logic act, input logic req);
        bit tick;
        int idleNow;
        int guestNow;
        if (!rst) begin
            mMode = 0; mAge = 0; mTsa = 0; mTt = 0; mPhase = 0;
            mGuest = 1'b0; mAddr = '0; mCause = '0;
        end else if (mMode == 0) begin
            if (li) begin
                mMode = 1; mAge = 0; mTsa = 0; mTt = 0;
                mGuest = g; mAddr = a; mCause = 2'b00;
            end
        end else if (mMode == 1) begin
            tick = (mAge % TPS) == TPS - 1;
            idleNow = IDLE_S - mTsa;
            guestNow = GUEST_S - mTt;
            mAge++;
            if (act) mTsa = 0;
            else if (tick) mTsa++;
            if (tick && mGuest) mTt++;
            if (lo) mMode = 0;
            else if (req) pushCmd(2'b01);
            else if (tick && !act && idleNow == 1) pushCmd(2'b10);
            else if (tick && mGuest && guestNow == 1) pushCmd(2'b11);
        end else begin
            if (mPhase == 0) mPhase = 1;
            else if (lo) mMode = 0;
            else begin
                mPhase = (mPhase + 1) % (ACK + 2);
                if (mPhase == 0) pushCmd(mCause);
            end
        end
    endtask

    task automatic applyAndModel(input logic li, input logic lo, input logic g, input logic [4:0] a,
                                 input logic act, input logic req);
        snapT s;
        LoggedIn = li; LoggedOut = lo; isGuest = g; PlayerAddress = a;
        Activity = act; LogoutReq = req;
        modelStep(li, lo, g, a, act, req);
        s.active = (mMode == 1);
        s.cmd = (mMode == 2) && (mPhase == 0);
        s.checkIdle = (mMode == 1);
        s.idle = 8'(IDLE_S - mTsa);
        s.warn = (mMode == 1) && ((IDLE_S - mTsa) <= WARN);
        s.guest = mGuest;
        s.addr = mAddr;
        s.cause = mCause;
        snapQ.push_back(s);
    endtask

    task automatic step(input logic li, input logic lo, input logic g, input logic [4:0] a,
                        input logic act, input logic req);
        @(negedge clk);
        applyAndModel(li, lo, g, a, act, req);
    endtask

    initial begin : monitor
        snapT s;
        cmdT c;
        bit ok;
        forever begin
            @(posedge clk);
            #1;
            if (snapQ.size() > 0) begin
                s = snapQ.pop_front();
                ok = (s.active == SessionActive) && (s.cmd == LogoutCommand) && (s.warn == IdleWarn) &&
                     (s.guest == SessionGuest) && (s.addr == SessionAddress) && (s.cause == LogoutCause) &&
                     (!s.checkIdle || (s.idle == IdleLeft));
                check("snapshot", ok, $sformatf(
                    "cyc %0d act/cmd/warn/guest/addr/cause/idle got %b/%b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%b/%0d/%0d/%0d",
                    cyc, SessionActive, LogoutCommand, IdleWarn, SessionGuest, SessionAddress, LogoutCause, IdleLeft,
                    s.active, s.cmd, s.warn, s.guest, s.addr, s.cause, s.idle));
            end
            if (LogoutCommand === 1'b1) begin
                obsCmd.push_back(cyc);
                if (cmdQ.size() == 0) begin
                    check("unexpectedCmd", 1'b0, $sformatf("command at cyc %0d, none expected", cyc));
                end else begin
                    c = cmdQ.pop_front();
                    check("cmdEvent", (c.cycle == cyc) && (c.cause == LogoutCause),
                          $sformatf("got cyc %0d cause %0d want cyc %0d cause %0d", cyc, LogoutCause, c.cycle, c.cause));
                end
            end
        end
    end

    task automatic runSession(input logic g, input logic [4:0] a, input int actMode, input int reqAt,
                              input int extAt, input int ackDelay, input bit noise, output int sessA);
        int j;
        int ackCycles;
        logic act;
        logic req;
        logic lo;
        obsCmd.delete();
        @(negedge clk);
        sessA = cyc + 1;
        applyAndModel(1'b1, 1'b0, g, a, 1'b0, 1'b0);
        j = 0;
        ackCycles = 0;
        while (mMode != 0 && j < 400) begin
            act = 1'b0; req = 1'b0; lo = 1'b0;
            if (mMode == 1) begin
                if (actMode == 1) act = (j % 3 == 0);
                else if (actMode == 2) act = ($urandom_range(0, 3) == 0);
                req = (j == reqAt) || (j == 60);
                lo = (j == extAt);
            end else begin
                if (noise) begin
                    act = 1'($urandom_range(0, 1));
                    req = 1'($urandom_range(0, 1));
                end
                lo = (ackCycles >= ackDelay);
                ackCycles++;
            end
            step(!lo, lo, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), act, req);
            j++;
        end
        check("sessionBound", j < 400, $sformatf("session still open after %0d cycles, limit 400", j));
        repeat (2) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        check("cmdDrained", cmdQ.size() == 0, $sformatf("%0d expected commands never seen, want 0", cmdQ.size()));
        cmdQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_cmd"}, LogoutCommand == 1'b0, $sformatf("got %b want 0", LogoutCommand));
        check({tag, "_active"}, SessionActive == 1'b0, $sformatf("got %b want 0", SessionActive));
        check({tag, "_guest"}, SessionGuest == 1'b0, $sformatf("got %b want 0", SessionGuest));
        check({tag, "_addr"}, SessionAddress == 5'd0, $sformatf("got %0d want 0", SessionAddress));
        check({tag, "_idle"}, IdleLeft == 8'd0, $sformatf("got %0d want 0", IdleLeft));
        check({tag, "_warn"}, IdleWarn == 1'b0, $sformatf("got %b want 0", IdleWarn));
        check({tag, "_cause"}, LogoutCause == 2'b00, $sformatf("got %0d want 0", LogoutCause));
    endtask

    function automatic int firstCmdOffset(input int sessA);
        if (obsCmd.size() == 0) return -1;
        return obsCmd[0] - sessA;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int sessA;
        int d;
        #1 rst = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (2) step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyAndModel(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        runSession(1'b0, 5'd5, 0, -1, -1, 2, 1'b0, sessA);
        d = firstCmdOffset(sessA);
        check("idleCmdAt", d == 12, $sformatf("command at A+%0d want A+12", d));
        check("idleCause", LogoutCause == 2'b10, $sformatf("got %0d want 2", LogoutCause));

        runSession(1'b1, 5'd17, 1, -1, -1, 1, 1'b0, sessA);
        d = firstCmdOffset(sessA);
        check("guestCmdAt", d == 20, $sformatf("command at A+%0d want A+20", d));
        check("guestCause", LogoutCause == 2'b11, $sformatf("got %0d want 3", LogoutCause));

        runSession(1'b0, 5'd5, 0, 2, -1, 2, 1'b0, sessA);
        d = firstCmdOffset(sessA);
        check("userCmdAt", d == 3, $sformatf("command at A+%0d want A+3", d));
        check("userHold", (SessionActive == 1'b0) && (SessionAddress == 5'd5) && (LogoutCause == 2'b01),
              $sformatf("active %b addr %0d cause %0d want 0/5/1", SessionActive, SessionAddress, LogoutCause));

        runSession(1'b0, 5'd11, 2, 1, -1, 35, 1'b1, sessA);
        check("retryCount", obsCmd.size() == 4, $sformatf("got %0d commands want 4", obsCmd.size()));
        for (int i = 1; i < obsCmd.size(); i++) begin
            check("retrySpacing", obsCmd[i] - obsCmd[i-1] == 10,
                  $sformatf("gap %0d got %0d want 10", i, obsCmd[i] - obsCmd[i-1]));
        end

        runSession(1'b1, 5'd22, 0, 3, 3, 0, 1'b0, sessA);
        check("extNoCmd", obsCmd.size() == 0, $sformatf("got %0d commands want 0", obsCmd.size()));
        check("extCause", LogoutCause == 2'b00, $sformatf("got %0d want 0", LogoutCause));

        // Drive a session into WAIT_ACK, then pull reset between clock edges.
        step(1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) step(1'b1, 1'b0, 1'b0, 5'd3, 1'b0, j == 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkResetOutputs("midAckReset");
        repeat (2) step(1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        LoggedIn = 1'b1;
        #2 rst = 1'b1;
        #1 check("noEarlyStart", (SessionActive == 1'b0) && (IdleLeft == 8'd0),
                 $sformatf("active %b idle %0d want 0/0", SessionActive, IdleLeft));
        applyAndModel(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        runSession(1'b0, 5'd26, 2, -1, -1, 3, 1'b1, sessA);

        for (int k = 0; k < 12; k++) begin
            runSession(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1,
                       int'($urandom_range(0, 25)), 1'b1, sessA);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
